// File: rtl/spmv_pkg.sv
// spmv_pkg
//   Shared definitions for the CSR sparse-matrix x dense-vector sequencer:
//   FSM state encoding, default datapath width and address-width helpers.
package spmv_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [3:0] {
      IDLE,
      INIT_W,
      PTR,
      PTR_W,
      NZ,
      NZ_W,
      MAC,
      WRITE,
      DONE
   } state_t;

   // Bits needed to index a memory of 'depth' entries (at least one bit).
   function automatic int aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // rowPtr has n_rows+1 entries.
   function automatic int ptr_aw(input int n_rows);
      return aw(n_rows + 1);
   endfunction

   // A rowPtr word must hold the value nnz itself (one past the last nonzero).
   function automatic int ptr_dw(input int nnz);
      return aw(nnz + 1);
   endfunction

endpackage

// File: rtl/spmv_mac.sv
// spmv_mac
//   Single multiply-accumulate lane. The product is combinational, the sum is
//   registered. Arithmetic wraps at DATA_W bits (two's complement, low bits of
//   the product are identical for signed and unsigned operands).
// Ports
//   clk  in   clock
//   rst  in   synchronous active-low reset, clears acc
//   clr  in   clear acc on the next edge (has priority over en)
//   en   in   acc <= acc + a*b on the next edge
//   a    in   DATA_W operand (matrix value)
//   b    in   DATA_W operand (vector element)
//   acc  out  DATA_W accumulator
module spmv_mac
   import spmv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] acc
);

   logic [DATA_W-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/spmv_row_sequencer.sv
// spmv_row_sequencer
//   Computes y = A*x for a CSR matrix, one row at a time. Walks rowPtr, reads
//   each (val,col) nonzero and x[col], accumulates in one shared MAC and writes
//   y[row] to the result RAM. One nonzero costs three cycles (NZ, NZ_W, MAC),
//   one row costs three more (PTR, PTR_W, WRITE).
//
//   All outputs are registered: each state computes its strobes/addresses on
//   its closing edge, so they are visible during the following cycle. The
//   memories return the addressed word in that same cycle, which is when the
//   following state captures it. done therefore appears in the cycle after the
//   DONE state, 3+3*N_ROWS+3*nnz cycles after the cycle in which start is seen.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   start / busy / done      host handshake (start pulse, busy level, done pulse)
//   ptr_rd, ptr_addr         rowPtr read request;  ptr_data   returned word
//   nz_rd, nz_addr           val/col read request; nz_val, nz_col returned
//   vec_rd, vec_addr         x read request;       vec_data   returned element
//   y_we, y_addr, y_data     result write port
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; on start request rowPtr[0]
// INIT_W | capture rowPtr[0] as the first nonzero index k
// PTR    | request rowPtr[row+1]
// PTR_W  | capture row end, clear acc; empty/descending row -> WRITE
// NZ     | request val/col at k
// NZ_W   | capture val, request x[col]
// MAC    | acc += val*x, k++; last nonzero of the row -> WRITE
// WRITE  | write y[row]=acc; last row -> DONE, else next row
// DONE   | raise done for one cycle, return to IDLE
module spmv_row_sequencer
   import spmv_pkg::*;
#(
   parameter int N_ROWS = 16,
   parameter int M_COLS = 16,
   parameter int NNZ    = 64,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      ptr_rd,
   output logic [ptr_aw(N_ROWS)-1:0] ptr_addr,
   input  logic [ptr_dw(NNZ)-1:0]    ptr_data,
   output logic                      nz_rd,
   output logic [aw(NNZ)-1:0]        nz_addr,
   input  logic [DATA_W-1:0]         nz_val,
   input  logic [aw(M_COLS)-1:0]     nz_col,
   output logic                      vec_rd,
   output logic [aw(M_COLS)-1:0]     vec_addr,
   input  logic [DATA_W-1:0]         vec_data,
   output logic                      y_we,
   output logic [aw(N_ROWS)-1:0]     y_addr,
   output logic [DATA_W-1:0]         y_data
);

   localparam int PA_W = ptr_aw(N_ROWS);
   localparam int K_W  = ptr_dw(NNZ);
   localparam int NA_W = aw(NNZ);
   localparam int C_W  = aw(M_COLS);
   localparam int R_W  = aw(N_ROWS);

   state_t            state;
   logic [R_W-1:0]    row;
   logic [K_W-1:0]    k;
   logic [K_W-1:0]    row_end;
   logic [K_W-1:0]    k_inc;
   logic [DATA_W-1:0] val;
   logic [DATA_W-1:0] acc;
   logic              mac_clr;
   logic              mac_en;

   assign k_inc   = k + K_W'(1);
   assign mac_clr = (state == PTR_W);
   assign mac_en  = (state == MAC);

   spmv_mac #(
      .DATA_W (DATA_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (val),
      .b   (vec_data),
      .acc (acc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         row      <= '0;
         k        <= '0;
         row_end  <= '0;
         val      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ptr_rd   <= 1'b0;
         ptr_addr <= '0;
         nz_rd    <= 1'b0;
         nz_addr  <= '0;
         vec_rd   <= 1'b0;
         vec_addr <= '0;
         y_we     <= 1'b0;
         y_addr   <= '0;
         y_data   <= '0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them.
         ptr_rd <= 1'b0;
         nz_rd  <= 1'b0;
         vec_rd <= 1'b0;
         y_we   <= 1'b0;
         done   <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  row      <= '0;
                  ptr_rd   <= 1'b1;
                  ptr_addr <= '0;
                  busy     <= 1'b1;
                  state    <= INIT_W;
               end
            end

            INIT_W: begin
               k     <= ptr_data;
               state <= PTR;
            end

            PTR: begin
               ptr_rd   <= 1'b1;
               ptr_addr <= PA_W'(row) + PA_W'(1);
               state    <= PTR_W;
            end

            PTR_W: begin
               // A descending rowPtr behaves like an empty row; k is kept so
               // later rows resume from where the walk actually is.
               row_end <= ptr_data;
               if (k >= ptr_data) begin
                  state <= WRITE;
               end else begin
                  state <= NZ;
               end
            end

            NZ: begin
               nz_rd   <= 1'b1;
               nz_addr <= NA_W'(k % K_W'(NNZ));
               state   <= NZ_W;
            end

            NZ_W: begin
               val      <= nz_val;
               vec_rd   <= 1'b1;
               vec_addr <= C_W'(nz_col);
               state    <= MAC;
            end

            MAC: begin
               k <= k_inc;
               if (k_inc >= row_end) begin
                  state <= WRITE;
               end else begin
                  state <= NZ;
               end
            end

            WRITE: begin
               y_we   <= 1'b1;
               y_addr <= row;
               y_data <= acc;
               if (row == R_W'(N_ROWS - 1)) begin
                  state <= DONE;
               end else begin
                  row   <= row + R_W'(1);
                  state <= PTR;
               end
            end

            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spmv_row_sequencer.sv
// tb_spmv_row_sequencer
//   Two instances: a 4-row/4-column/16-nonzero one for the small directed
//   matrices and a default-sized one for random CSR products. Memories are
//   modelled as read ports that return the word at the DUT's registered address
//   while the matching strobe is high, zero otherwise. Expected y values come
//   from a plain CSR dot-product model over the bench's own arrays.
module tb_spmv_row_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // small instance
   logic        start_s, busy_s, done_s, ptr_rd_s, nz_rd_s, vec_rd_s, y_we_s;
   logic [2:0]  ptr_addr_s;
   logic [4:0]  ptr_data_s;
   logic [3:0]  nz_addr_s;
   logic [31:0] nz_val_s;
   logic [1:0]  nz_col_s;
   logic [1:0]  vec_addr_s;
   logic [31:0] vec_data_s;
   logic [1:0]  y_addr_s;
   logic [31:0] y_data_s;

   // default-sized instance
   logic        start_b, busy_b, done_b, ptr_rd_b, nz_rd_b, vec_rd_b, y_we_b;
   logic [4:0]  ptr_addr_b;
   logic [6:0]  ptr_data_b;
   logic [5:0]  nz_addr_b;
   logic [31:0] nz_val_b;
   logic [3:0]  nz_col_b;
   logic [3:0]  vec_addr_b;
   logic [31:0] vec_data_b;
   logic [3:0]  y_addr_b;
   logic [31:0] y_data_b;

   int          ptr_mem [0:16];
   logic [31:0] val_mem [0:63];
   logic [3:0]  col_mem [0:63];
   logic [31:0] x_mem   [0:15];
   logic [31:0] ey      [0:15];
   logic [31:0] ym      [0:15];

   int checks   = 0;
   int failures = 0;
   int nwe, ndone;

   assign ptr_data_s = ptr_rd_s ? 5'(ptr_mem[ptr_addr_s]) : 5'd0;
   assign nz_val_s   = nz_rd_s  ? val_mem[nz_addr_s] : 32'd0;
   assign nz_col_s   = nz_rd_s  ? col_mem[nz_addr_s][1:0] : 2'd0;
   assign vec_data_s = vec_rd_s ? x_mem[vec_addr_s] : 32'd0;

   assign ptr_data_b = ptr_rd_b ? 7'(ptr_mem[ptr_addr_b]) : 7'd0;
   assign nz_val_b   = nz_rd_b  ? val_mem[nz_addr_b] : 32'd0;
   assign nz_col_b   = nz_rd_b  ? col_mem[nz_addr_b] : 4'd0;
   assign vec_data_b = vec_rd_b ? x_mem[vec_addr_b] : 32'd0;

   spmv_row_sequencer #(.N_ROWS(4), .M_COLS(4), .NNZ(16), .DATA_W(32)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
      .ptr_rd(ptr_rd_s), .ptr_addr(ptr_addr_s), .ptr_data(ptr_data_s),
      .nz_rd(nz_rd_s), .nz_addr(nz_addr_s), .nz_val(nz_val_s), .nz_col(nz_col_s),
      .vec_rd(vec_rd_s), .vec_addr(vec_addr_s), .vec_data(vec_data_s),
      .y_we(y_we_s), .y_addr(y_addr_s), .y_data(y_data_s)
   );

   spmv_row_sequencer dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .ptr_rd(ptr_rd_b), .ptr_addr(ptr_addr_b), .ptr_data(ptr_data_b),
      .nz_rd(nz_rd_b), .nz_addr(nz_addr_b), .nz_val(nz_val_b), .nz_col(nz_col_b),
      .vec_rd(vec_rd_b), .vec_addr(vec_addr_b), .vec_data(vec_data_b),
      .y_we(y_we_b), .y_addr(y_addr_b), .y_data(y_data_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // CSR reference: y[r] = sum of val[k]*x[col[k]] over k in [cur, rowPtr[r+1]),
   // where cur starts at rowPtr[0] and only moves forward.
   task automatic model(input int n, input int cap, input int cmask, output int nnz);
      int cur;
      logic [31:0] s;
      cur = ptr_mem[0];
      nnz = 0;
      for (int r = 0; r < n; r++) begin
         int e;
         e = ptr_mem[r + 1];
         s = 32'd0;
         if (e > cur) begin
            for (int kk = cur; kk < e; kk++)
               s = s + val_mem[kk % cap] * x_mem[int'(col_mem[kk % cap]) & cmask];
            nnz += e - cur;
            cur = e;
         end
         ey[r] = s;
      end
   endtask

   // Observe one cycle (#1 after the edge) and record result writes / done.
   task automatic observe(input bit big);
      @(posedge clk);
      #1;
      if (big ? y_we_b : y_we_s) begin
         nwe++;
         if (big) ym[y_addr_b] = y_data_b;
         else     ym[y_addr_s] = y_data_s;
      end
      if (big ? done_b : done_s) ndone++;
   endtask

   // Pulse start; cycle 1 is the first cycle after start is sampled. inj
   // drives start high in chosen later cycles; rst_cyc pulls reset in that cycle.
   task automatic run(input bit big, input logic [63:0] inj, input int rst_cyc,
                      output int lat);
      int cyc;
      lat = -1;
      @(negedge clk);
      if (big) start_b = 1'b1; else start_s = 1'b1;
      cyc = 0;
      while (cyc < 1000 && lat < 0) begin
         observe(big);
         cyc++;
         if (big) start_b = (cyc < 64) ? inj[cyc[5:0]] : 1'b0;
         else     start_s = (cyc < 64) ? inj[cyc[5:0]] : 1'b0;
         if (cyc == rst_cyc) begin
            rst = 1'b0;
            lat = 0;
         end else if (big ? done_b : done_s) begin
            lat = cyc;
         end
      end
      start_s = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic go(input bit big, input logic [63:0] inj, input int n, input int cap,
                     input int cmask, input string tag, output int lat);
      int nnz;
      model(n, cap, cmask, nnz);
      for (int r = 0; r < 16; r++) ym[r] = 32'hDEAD_BEEF;
      nwe   = 0;
      ndone = 0;
      run(big, inj, -1, lat);
      for (int i = 0; i < 4; i++) observe(big);
      chk({tag, "_lat"}, 64'(lat), 64'(3 + 3 * n + 3 * nnz));
      chk({tag, "_nwe"}, 64'(nwe), 64'(n));
      chk({tag, "_ndone"}, 64'(ndone), 64'd1);
      chk({tag, "_idle"}, 64'(big ? busy_b : busy_s), 64'd0);
      for (int r = 0; r < n; r++)
         chk($sformatf("%s_y%0d", tag, r), 64'(ym[r]), 64'(ey[r]));
   endtask

   task automatic load_identity();
      for (int i = 0; i < 4; i++) begin
         ptr_mem[i] = i;
         val_mem[i] = 32'd1;
         col_mem[i] = 4'(i);
         x_mem[i]   = 32'(i + 1);
      end
      ptr_mem[4] = 4;
   endtask

   initial begin
      int lat;
      rst     = 1'b0;
      start_s = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < 17; i++) ptr_mem[i] = 0;
      for (int i = 0; i < 64; i++) begin val_mem[i] = 32'd0; col_mem[i] = 4'd0; end
      for (int i = 0; i < 16; i++) x_mem[i] = 32'd0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   64'(busy_b), 64'd0);
      chk("rst_done",   64'(done_b), 64'd0);
      chk("rst_strobe", 64'({ptr_rd_b, nz_rd_b, vec_rd_b, y_we_b}), 64'd0);
      chk("rst_addr",   64'({ptr_addr_b, nz_addr_b, vec_addr_b, y_addr_b}), 64'd0);
      chk("rst_ydata",  64'(y_data_b), 64'd0);
      chk("rst_small",  64'({busy_s, done_s, y_we_s, y_data_s}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // identity, x={1,2,3,4}
      load_identity();
      go(1'b0, 64'd0, 4, 16, 3, "ident", lat);
      chk("ident_lat27", 64'(lat), 64'd27);
      for (int r = 0; r < 4; r++)
         chk($sformatf("ident_const_y%0d", r), 64'(ym[r]), 64'(r + 1));

      // start pulsed in PTR (cycle 2), NZ_W (cycle 5) and DONE (cycle 26)
      go(1'b0, (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 26), 4, 16, 3, "ignstart", lat);
      chk("ignstart_lat27", 64'(lat), 64'd27);

      // empty rows around a three-nonzero row
      ptr_mem[0] = 0; ptr_mem[1] = 0; ptr_mem[2] = 3; ptr_mem[3] = 3; ptr_mem[4] = 3;
      val_mem[0] = 32'd2; val_mem[1] = 32'd3; val_mem[2] = 32'd4;
      col_mem[0] = 4'd0;  col_mem[1] = 4'd1;  col_mem[2] = 4'd2;
      for (int i = 0; i < 4; i++) x_mem[i] = 32'd1;
      go(1'b0, 64'd0, 4, 16, 3, "sparse", lat);
      chk("sparse_y0", 64'(ym[0]), 64'd0);
      chk("sparse_y1", 64'(ym[1]), 64'd9);
      chk("sparse_y3", 64'(ym[3]), 64'd0);

      // wrap-around arithmetic and a negative product
      ptr_mem[0] = 0; ptr_mem[1] = 1; ptr_mem[2] = 2; ptr_mem[3] = 2; ptr_mem[4] = 2;
      val_mem[0] = 32'h7FFF_FFFF; col_mem[0] = 4'd0; x_mem[0] = 32'd2;
      val_mem[1] = 32'hFFFF_FFFB; col_mem[1] = 4'd1; x_mem[1] = 32'd3;
      go(1'b0, 64'd0, 4, 16, 3, "wrap", lat);
      chk("wrap_y0", 64'(ym[0]), 64'h0000_0000_FFFF_FFFE);
      chk("wrap_y1", 64'(ym[1]), 64'h0000_0000_FFFF_FFF1);

      // descending rowPtr: row 0 and row 2 behave as empty, k is kept
      ptr_mem[0] = 2; ptr_mem[1] = 1; ptr_mem[2] = 3; ptr_mem[3] = 3; ptr_mem[4] = 4;
      for (int i = 0; i < 16; i++) begin
         val_mem[i] = $urandom;
         col_mem[i] = 4'($urandom_range(0, 3));
      end
      for (int i = 0; i < 4; i++) x_mem[i] = $urandom;
      go(1'b0, 64'd0, 4, 16, 3, "desc", lat);
      chk("desc_lat", 64'(lat), 64'd21);

      // reset during the MAC cycle of row 2 (cycle 18), then a clean rerun
      load_identity();
      for (int r = 0; r < 16; r++) ym[r] = 32'hDEAD_BEEF;
      nwe   = 0;
      ndone = 0;
      run(1'b0, 64'd0, 18, lat);
      observe(1'b0);
      chk("abort_busy", 64'(busy_s), 64'd0);
      chk("abort_ywe",  64'(y_we_s), 64'd0);
      chk("abort_done", 64'(done_s), 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) observe(1'b0);
      chk("abort_nwe",   64'(nwe), 64'd2);
      chk("abort_ndone", 64'(ndone), 64'd0);
      chk("abort_y1",    64'(ym[1]), 64'd2);
      chk("abort_y2",    64'(ym[2]), 64'hDEAD_BEEF);
      go(1'b0, 64'd0, 4, 16, 3, "rerun", lat);

      // random CSR products on the default-sized instance
      for (int t = 0; t < 3; t++) begin
         ptr_mem[0] = int'($urandom_range(0, 3));
         for (int r = 1; r <= 16; r++) begin
            ptr_mem[r] = ptr_mem[r - 1] + int'($urandom_range(0, 5));
            if (ptr_mem[r] > 64) ptr_mem[r] = 64;
         end
         for (int i = 0; i < 64; i++) begin
            val_mem[i] = $urandom;
            col_mem[i] = 4'($urandom_range(0, 15));
         end
         for (int i = 0; i < 16; i++) x_mem[i] = $urandom;
         go(1'b1, 64'd0, 16, 64, 15, $sformatf("rand%0d", t), lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
